// File: rtl/decryption_core_iter.sv
// Iterative AES inverse cipher (InvCipher) for one 128-bit block. It uses a single shared
// inverse round datapath, a round counter, a v/ready input handshake and a v/yumi output handshake.
module decryption_core_iter #(
  parameter int rounds_p = 10
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        v_i,
  output logic                        ready_o,
  input  logic [127:0]                ciphertext_i,
  input  logic [128*(rounds_p+1)-1:0] round_keys_i,
  output logic                        v_o,
  output logic [127:0]                data_o,
  input  logic                        yumi_i
);
  localparam int cnt_w_lp = $clog2(rounds_p + 1);
  localparam int rk_w_lp  = 128 * (rounds_p + 1);

  if (!(rounds_p == 10 || rounds_p == 12 || rounds_p == 14)) begin : g_bad_rounds
    $error("decryption_core_iter: rounds_p must be 10, 12 or 14");
  end

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

  state_e              state_q, state_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic [127:0]        st_q, st_d;
  logic [rk_w_lp-1:0]  rk_q, rk_d;
  logic [127:0]        sub_w, rk_sel_w, ark_w, mix_w;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8) as x^254 (maps 0 to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t, x2, x3, x6, x12, x15, x30, x60, x120, x240;
    t    = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    x2   = gf_mul(t, t);
    x3   = gf_mul(x2, t);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  // Byte k = 4*col + row sits at [127-8k -: 8]; row r takes its byte from column (c - r) mod 4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int row_lp = gi % 4;
    localparam int src_lp = 4 * (((gi / 4) - row_lp + 4) % 4) + row_lp;
    assign sub_w[127-8*gi -: 8] = inv_sbox(st_q[127-8*src_lp -: 8]);
  end

  assign rk_sel_w = (state_q == FINAL) ? rk_q[127:0] : rk_q[128*cnt_q +: 128];
  assign ark_w    = sub_w ^ rk_sel_w;

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark_w[127-32*gi -: 8];
    assign a1 = ark_w[119-32*gi -: 8];
    assign a2 = ark_w[111-32*gi -: 8];
    assign a3 = ark_w[103-32*gi -: 8];
    assign mix_w[127-32*gi -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign mix_w[119-32*gi -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign mix_w[111-32*gi -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign mix_w[103-32*gi -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    rk_d    = rk_q;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          st_d    = ciphertext_i ^ round_keys_i[128*rounds_p +: 128];
          rk_d    = round_keys_i;
          cnt_d   = cnt_w_lp'(rounds_p - 1);
          state_d = ROUND;
        end
      end
      ROUND: begin
        st_d = mix_w;
        if (cnt_q == cnt_w_lp'(1)) state_d = FINAL;
        else                       cnt_d   = cnt_q - cnt_w_lp'(1);
      end
      FINAL: begin
        st_d    = ark_w;
        state_d = DONE;
      end
      DONE: begin
        if (yumi_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
    end
  end

  // Key bundle is only consumed after acceptance, so it needs no reset.
  always_ff @(posedge clk_i) begin
    rk_q <= rk_d;
  end

  assign ready_o = (state_q == IDLE) & ~reset_i;
  assign v_o     = (state_q == DONE);
  assign data_o  = (state_q == DONE) ? st_q : '0;

endmodule
